msoc_cpu1_oci_dct_packer: RTL

//  Producer end of the OCI direct-control-transfer (DCT) trace path: packs 2-bit DCT codes from
//  the CPU1 retire stage into the 30-bit dct_buffer / 4-bit dct_count word that the OCI test bench
//  and trace capture consume. Emits packed words over a valid/ready handshake and owns the

---
 rtl/msoc_oci_pkg.sv | 13 +
 rtl/msoc_cpu1_oci_dct_outreg.sv | 33 +++
 rtl/msoc_cpu1_oci_dct_packer.sv | 80 ++++++++
 3 files changed

// File: rtl/msoc_oci_pkg.sv
// msoc_oci_pkg: shared DCT trace constants, code encodings and packer states
package msoc_oci_pkg;
    localparam int CODE_W = 2;
    localparam int SLOTS  = 15;
    localparam int BUF_W  = CODE_W * SLOTS;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);
    localparam logic [CODE_W-1:0] DCT_CODE_SEQ      = 2'b00;
    localparam logic [CODE_W-1:0] DCT_CODE_TAKEN    = 2'b01;
    localparam logic [CODE_W-1:0] DCT_CODE_NOTTAKEN = 2'b10;
    localparam logic [CODE_W-1:0] DCT_CODE_ESC      = 2'b11;
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ENDED} state_e;
endpackage

// File: rtl/msoc_cpu1_oci_dct_outreg.sv
// msoc_cpu1_oci_dct_outreg: one-entry valid/ready holding register for packed words
module msoc_cpu1_oci_dct_outreg
    import msoc_oci_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [BUF_W+CNT_W-1:0] load_data,
    input  logic                   ready,
    output logic                   valid,
    output logic [BUF_W+CNT_W-1:0] data
);
    logic                   valid_q, valid_d;
    logic [BUF_W+CNT_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = load ? 1'b1 : (ready ? 1'b0 : valid_q);
        data_d  = load ? load_data : data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
endmodule

// File: rtl/msoc_cpu1_oci_dct_packer.sv
// msoc_cpu1_oci_dct_packer: packs 2-bit DCT codes into 30-bit trace words and drains on test end
module msoc_cpu1_oci_dct_packer
    import msoc_oci_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    output logic              code_ready,
    input  logic              flush,
    input  logic              test_ending,
    output logic              dct_valid,
    input  logic              dct_ready,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              test_has_ended,
    output logic              overflow
);
    state_e             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d, out_buf;
    logic [CNT_W-1:0]   cnt_q, cnt_d, out_cnt, cnt_next;
    logic               pend_q, pend_d, ovf_q, ovf_d;
    logic               free, full, acc, flush_req, xfer;

    always_comb begin
        free       = !dct_valid | dct_ready;
        full       = cnt_q == FULL_CNT;
        code_ready = !(full & !free) & (state_q != ST_ENDED);
        acc        = code_valid & code_ready;
        flush_req  = flush | pend_q | (state_q == ST_DRAIN);
        cnt_next   = cnt_q + CNT_W'(acc);
        // A full buffer is emitted as-is; a code accepted alongside starts the next word
        out_buf    = full ? buf_q : (acc ? {buf_q[BUF_W-CODE_W-1:0], code} : buf_q);
        out_cnt    = full ? cnt_q : cnt_next;
        xfer       = free & (full | (cnt_next == FULL_CNT) | (flush_req & (cnt_next != '0)));
        buf_d      = xfer ? ((full & acc) ? {{(BUF_W-CODE_W){1'b0}}, code} : '0) : out_buf;
        cnt_d      = xfer ? CNT_W'(full & acc) : out_cnt;
        pend_d     = (flush | pend_q) & !xfer & (cnt_d != '0);
        ovf_d      = ovf_q | (code_valid & !code_ready);
        state_d    = state_q;
        if (state_q == ST_RUN && test_ending)
            state_d = ST_DRAIN;
        else if (state_q == ST_DRAIN && cnt_q == '0 && !dct_valid && !code_valid)
            state_d = ST_ENDED;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            buf_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n)
            assert (!(full & acc & !xfer));
    end

    msoc_cpu1_oci_dct_outreg u_outreg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (xfer),
        .load_data ({out_buf, out_cnt}),
        .ready     (dct_ready),
        .valid     (dct_valid),
        .data      ({dct_buffer, dct_count})
    );

    assign test_has_ended = state_q == ST_ENDED;
    assign overflow       = ovf_q;
endmodule
